hwag_capture_seq: RTL and testbench

Sequencer for the crank-wheel capture path. It takes the rise/fall strobes produced by the filter and edge-capture stage and selects the active edge. It measures the tooth period with a free-running timer and finds the missing-tooth gap. It then runs the sync state machine that gives the angle generator a tooth number, the last two periods and sync/error strobes.

---
 rtl/hwag_capture_pkg.sv | 15 +
 rtl/hwag_period_timer.sv | 30 +++
 rtl/hwag_capture_seq.sv | 178 +++++++++++++++++
 tb/tb_hwag_capture_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hwag_capture_pkg.sv
// Shared types and constants for the crank-wheel capture sequencer.
package hwag_capture_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FIRST   = 3'd1,
    MEASURE = 3'd2,
    SEARCH  = 3'd3,
    SYNC    = 3'd4
  } state_e;

  // Gap threshold is period_prev << GAP_SHIFT (i.e. twice the reference period).
  localparam int unsigned GAP_SHIFT = 1;

endpackage

// File: rtl/hwag_period_timer.sv
// Saturating period timer: restarts at 1 on an accepted edge, holds at all-ones.
module hwag_period_timer #(
  parameter int unsigned WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic             load,
  output logic [WIDTH-1:0] count,
  output logic             sat_c
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  assign sat_c = (count == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= WIDTH'(1);
    end else if (run && !sat_c) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hwag_capture_seq.sv
// Crank-wheel capture sequencer: edge select, tooth period measurement,
// missing-tooth gap detection and sync state machine for the angle generator.
module hwag_capture_seq
  import hwag_capture_pkg::*;
#(
  parameter int unsigned TCNT_WIDTH  = 24,
  parameter int unsigned TOOTH_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   edge_rise,
  input  logic                   edge_fall,
  input  logic                   cfg_edge_sel,
  input  logic [TOOTH_WIDTH-1:0] cfg_teeth,
  output logic [TCNT_WIDTH-1:0]  period,
  output logic [TCNT_WIDTH-1:0]  period_prev,
  output logic [TOOTH_WIDTH-1:0] tooth_num,
  output logic                   synced,
  output logic                   tooth_stb,
  output logic                   gap_stb,
  output logic                   err_stb
);

  localparam int unsigned EXT_W = TCNT_WIDTH + 1;

  state_e                 state_q, state_d;
  logic                   acc_c, running_c, sat_c, timeout_c, gap_c, last_tooth_c;
  logic [TCNT_WIDTH-1:0]  tmr_q;
  logic [EXT_W-1:0]       thresh_c;
  logic [TCNT_WIDTH-1:0]  period_d, period_prev_d;
  logic [TOOTH_WIDTH-1:0] tooth_d;
  logic                   synced_d, tooth_stb_d, gap_stb_d, err_stb_d;

  assign acc_c        = cfg_edge_sel ? edge_fall : edge_rise;
  assign running_c    = (state_q != IDLE);
  assign timeout_c    = running_c && sat_c && !acc_c;
  // One extra bit so doubling a near-saturated reference cannot wrap.
  assign thresh_c     = EXT_W'(period_prev) << GAP_SHIFT;
  assign gap_c        = (EXT_W'(tmr_q) >= thresh_c);
  assign last_tooth_c = (tooth_num == (cfg_teeth - TOOTH_WIDTH'(1)));

  // Timer value at the accepted edge is the measured period.
  hwag_period_timer #(
    .WIDTH (TCNT_WIDTH)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (!ena),
    .run   (running_c),
    .load  (acc_c && running_c),
    .count (tmr_q),
    .sat_c (sat_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!ena) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = FIRST;
        FIRST:   if (acc_c) state_d = MEASURE;
        MEASURE: begin
          if (acc_c)          state_d = SEARCH;
          else if (timeout_c) state_d = FIRST;
        end
        SEARCH: begin
          if (acc_c && gap_c) state_d = SYNC;
          else if (timeout_c) state_d = FIRST;
        end
        SYNC: begin
          // Gap must coincide with the last tooth; any mismatch drops sync.
          if (acc_c && (gap_c != last_tooth_c)) state_d = SEARCH;
          else if (timeout_c)                   state_d = FIRST;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    period_d      = period;
    period_prev_d = period_prev;
    tooth_d       = tooth_num;
    tooth_stb_d   = 1'b0;
    gap_stb_d     = 1'b0;
    err_stb_d     = 1'b0;
    synced_d      = (state_d == SYNC);
    if (!ena) begin
      period_d      = '0;
      period_prev_d = '0;
      tooth_d       = '0;
    end else begin
      unique case (state_q)
        MEASURE: begin
          if (acc_c) begin
            period_d      = tmr_q;
            period_prev_d = tmr_q;
          end else if (timeout_c) begin
            period_d      = '0;
            period_prev_d = '0;
          end
        end
        SEARCH: begin
          if (acc_c) begin
            period_d = tmr_q;
            if (gap_c) begin
              tooth_d   = '0;
              gap_stb_d = 1'b1;
            end else begin
              period_prev_d = tmr_q;
            end
          end else if (timeout_c) begin
            err_stb_d     = 1'b1;
            period_d      = '0;
            period_prev_d = '0;
          end
        end
        SYNC: begin
          if (acc_c) begin
            period_d    = tmr_q;
            tooth_stb_d = 1'b1;
            if (last_tooth_c) begin
              if (gap_c) begin
                tooth_d   = '0;
                gap_stb_d = 1'b1;
              end else begin
                err_stb_d     = 1'b1;
                period_prev_d = tmr_q;
              end
            end else if (gap_c) begin
              err_stb_d = 1'b1;
              tooth_d   = '0;
            end else begin
              tooth_d       = tooth_num + TOOTH_WIDTH'(1);
              period_prev_d = tmr_q;
            end
          end else if (timeout_c) begin
            err_stb_d     = 1'b1;
            period_d      = '0;
            period_prev_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period      <= '0;
      period_prev <= '0;
      tooth_num   <= '0;
      synced      <= 1'b0;
      tooth_stb   <= 1'b0;
      gap_stb     <= 1'b0;
      err_stb     <= 1'b0;
    end else begin
      period      <= period_d;
      period_prev <= period_prev_d;
      tooth_num   <= tooth_d;
      synced      <= synced_d;
      tooth_stb   <= tooth_stb_d;
      gap_stb     <= gap_stb_d;
      err_stb     <= err_stb_d;
    end
  end

endmodule

// File: tb/tb_hwag_capture_seq.sv
// Bench for hwag_capture_seq: randomized 60-2 style wheel against an
// edge-timestamp reference model, plus directed lock/loss scenarios.
`timescale 1ns/1ps
module tb_hwag_capture_seq;

  localparam int unsigned TW    = 16;
  localparam int unsigned NW    = 6;
  localparam int          TEETH = 58;
  localparam longint      TMAX  = 65535;
  localparam int M_IDLE = 0, M_FIRST = 1, M_MEAS = 2, M_SEARCH = 3, M_SYNC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b0;
  logic          edge_rise = 1'b0;
  logic          edge_fall = 1'b0;
  logic          cfg_edge_sel = 1'b0;
  logic [NW-1:0] cfg_teeth = NW'(TEETH);
  logic [TW-1:0] period, period_prev;
  logic [NW-1:0] tooth_num;
  logic          synced, tooth_stb, gap_stb, err_stb;

  hwag_capture_seq #(
    .TCNT_WIDTH  (TW),
    .TOOTH_WIDTH (NW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .edge_rise    (edge_rise),
    .edge_fall    (edge_fall),
    .cfg_edge_sel (cfg_edge_sel),
    .cfg_teeth    (cfg_teeth),
    .period       (period),
    .period_prev  (period_prev),
    .tooth_num    (tooth_num),
    .synced       (synced),
    .tooth_stb    (tooth_stb),
    .gap_stb      (gap_stb),
    .err_stb      (err_stb)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the cycle of the last accepted edge, not a counter.
  int     mode = M_IDLE;
  longint cyc = 0, ref_c = 0;
  longint per = 0, prev = 0, tooth = 0;
  bit     e_t, e_g, e_e;

  int n_pass = 0, n_total = 0;
  int n_err_seen = 0, n_tstb_seen = 0;
  bit wrong_line = 1'b0;
  int base_p;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [63:0] dut_vec();
    return 64'({period, period_prev, tooth_num, synced, tooth_stb, gap_stb, err_stb});
  endfunction

  function automatic logic [63:0] exp_vec();
    return 64'({TW'(per), TW'(prev), NW'(tooth), (mode == M_SYNC), e_t, e_g, e_e});
  endfunction

  task automatic model_reset();
    mode = M_IDLE; per = 0; prev = 0; tooth = 0;
    e_t = 1'b0; e_g = 1'b0; e_e = 1'b0;
  endtask

  task automatic model_eval();
    longint tmr, m;
    bit     acc, gap;
    e_t = 1'b0; e_g = 1'b0; e_e = 1'b0;
    if (!rst || !ena) begin
      model_reset();
    end else begin
      tmr = (mode == M_IDLE) ? 0 : (((cyc - ref_c) > TMAX) ? TMAX : (cyc - ref_c));
      acc = cfg_edge_sel ? edge_fall : edge_rise;
      if (mode == M_IDLE) begin
        mode  = M_FIRST;
        ref_c = cyc + 1;
      end else if (acc) begin
        m     = tmr;
        ref_c = cyc;
        gap   = (m >= 2 * prev);
        case (mode)
          M_FIRST: mode = M_MEAS;
          M_MEAS: begin per = m; prev = m; mode = M_SEARCH; end
          M_SEARCH: begin
            per = m;
            if (gap) begin tooth = 0; e_g = 1'b1; mode = M_SYNC; end
            else prev = m;
          end
          M_SYNC: begin
            per = m; e_t = 1'b1;
            if (tooth == longint'(cfg_teeth) - 1) begin
              if (gap) begin tooth = 0; e_g = 1'b1; end
              else begin e_e = 1'b1; prev = m; mode = M_SEARCH; end
            end else if (gap) begin
              e_e = 1'b1; tooth = 0; mode = M_SEARCH;
            end else begin
              tooth = tooth + 1; prev = m;
            end
          end
          default: ;
        endcase
      end else if (tmr == TMAX) begin
        if (mode == M_SYNC || mode == M_SEARCH) e_e = 1'b1;
        mode = M_FIRST; per = 0; prev = 0;
      end
    end
    cyc++;
  endtask

  // One clock: drive the selected line with 'a', random noise on the other.
  task automatic step(input bit a);
    logic s, o;
    s = wrong_line ? 1'b0 : a;
    o = wrong_line ? a : ($urandom_range(0, 7) == 0);
    if (cfg_edge_sel) begin edge_fall = s; edge_rise = o; end
    else begin edge_rise = s; edge_fall = o; end
    model_eval();
    @(posedge clk); #1;
    chk("cycle", dut_vec(), exp_vec());
    if (err_stb)   n_err_seen++;
    if (tooth_stb) n_tstb_seen++;
  endtask

  task automatic interval(input int len);
    repeat (len - 1) step(1'b0);
    step(1'b1);
  endtask

  task automatic teeth(input int n);
    repeat (n) interval(base_p + int'($urandom_range(0, 2)) - 1);
  endtask

  task automatic gap();
    interval(3 * base_p);
  endtask

  task automatic rev();
    teeth(TEETH - 1);
    gap();
  endtask

  task automatic chk_lock(input string tag);
    chk(tag, 64'({synced, tooth_num, gap_stb}), 64'({1'b1, NW'(0), 1'b1}));
  endtask

  initial begin
    base_p = 8 + int'($urandom_range(0, 4));
    model_reset();
    repeat (3) step(1'b0);
    chk("reset", dut_vec(), 64'd0);

    // Nominal lock
    rst = 1'b1; ena = 1'b1;
    repeat (5) step(1'b0);
    repeat (3) rev();
    chk_lock("nominal_lock");

    // Early gap
    teeth(29);
    gap();
    chk("early_err", 64'({synced, err_stb}), 64'({1'b0, 1'b1}));
    teeth(27);
    gap();
    chk_lock("early_relock");

    // Missing gap
    teeth(TEETH - 1);
    interval(base_p);
    chk("missing_err", 64'({synced, err_stb, tooth_stb}), 64'({1'b0, 1'b1, 1'b1}));
    n_tstb_seen = 0;
    teeth(20);
    chk("missing_no_tstb", 64'(n_tstb_seen), 64'd0);
    gap();
    chk_lock("missing_relock");

    // Falling-edge select: rises alone must not lock
    ena = 1'b0;
    repeat (3) step(1'b0);
    cfg_edge_sel = 1'b1; ena = 1'b1;
    wrong_line = 1'b1; n_tstb_seen = 0;
    rev();
    chk("sel_no_lock", 64'(synced), 64'd0);
    chk("sel_no_tstb", 64'(n_tstb_seen), 64'd0);
    wrong_line = 1'b0;
    repeat (2) rev();
    chk_lock("sel_lock");

    // Async reset mid-sync
    teeth(20);
    chk("rst_pre_tooth", 64'({synced, tooth_num}), 64'({1'b1, NW'(20)}));
    #1 rst = 1'b0;
    #1 chk("rst_async", dut_vec(), 64'd0);
    model_reset();
    step(1'b0);
    rst = 1'b1;
    repeat (2) rev();
    chk_lock("rst_relock");

    // Timeout while synced
    n_err_seen = 0;
    repeat (int'(TMAX) + 5) step(1'b0);
    chk("timeout_err_once", 64'(n_err_seen), 64'd1);
    chk("timeout_clear", 64'({synced, period, period_prev}), 64'd0);
    repeat (2) rev();
    chk_lock("timeout_relock");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
